rol_iter: RTL and testbench

ROL_ITER -- requirements
Module: rol_iter

---
 rtl/rol_iter.sv | 95 +++++++++
 tb/tb_rol_iter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rol_iter.sv
// Iterative rotate-left unit: rotates Ain left by (shamt mod WIDTH) one bit per clock,
// then presents the result on Aout with a one-cycle done pulse.
module rol_iter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Ain,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Aout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] aout_q,  aout_d;

    logic [CW-1:0]    n_load;
    logic [WIDTH-1:0] work_rot;

    // Effective rotate amount; amounts of WIDTH or more wrap around.
    assign n_load   = CW'(32'(shamt) % WIDTH);
    assign work_rot = {work_q[WIDTH-2:0], work_q[WIDTH-1]};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        aout_d  = aout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = Ain;
                    cnt_d  = n_load;
                    if (n_load == '0) begin
                        // Zero rotation: the operand itself is the result.
                        aout_d  = Ain;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = work_rot;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Only the final rotation is published; intermediate steps stay internal.
                    aout_d  = work_rot;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            aout_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            aout_q  <= aout_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign Aout = aout_q;

endmodule

// File: tb/tb_rol_iter.sv
// Self-checking bench for rol_iter: directed cases plus 1000 random back-to-back
// requests compared against an arithmetic rotate model.
module tb_rol_iter;

    localparam int WIDTH = 16;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] Ain;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Aout;

    int total;
    int bad;

    logic [WIDTH-1:0] last_res;
    logic [WIDTH-1:0] got_res;

    rol_iter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Ain   (Ain),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .Aout  (Aout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rotate-left: take the upper half of the doubled word shifted left.
    function automatic logic [WIDTH-1:0] ref_rotl(input logic [WIDTH-1:0] a, input int s);
        logic [2*WIDTH-1:0] dbl;
        int n;
        n   = s % WIDTH;
        dbl = {a, a} << n;
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] ref_rotr(input logic [WIDTH-1:0] a, input int s);
        logic [31:0] w;
        int n;
        n = s % WIDTH;
        w = 32'(a);
        w = (w >> n) | (w << (WIDTH - n));
        return w[WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from an IDLE cycle and follow it to the IDLE cycle after done.
    // With hold=1 start stays high and Ain/shamt are scrambled while the unit is busy.
    task automatic run_req(input logic [WIDTH-1:0] a, input int s, input bit hold);
        logic [WIDTH-1:0] exp;
        int n;
        n     = s % WIDTH;
        exp   = ref_rotl(a, s);
        start = 1'b1;
        Ain   = a;
        shamt = SHW'(s);
        tick();
        for (int k = 0; k <= n; k++) begin
            check("busy_active", 32'(busy), 32'd1);
            check("done_timing", 32'(done), (k == n) ? 32'd1 : 32'd0);
            if (k < n) check("aout_hold", 32'(Aout), 32'(last_res));
            else begin
                check("aout_result", 32'(Aout), 32'(exp));
                got_res = Aout;
            end
            if (hold) begin
                start = 1'b1;
                Ain   = WIDTH'($urandom);
                shamt = SHW'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_aout", 32'(Aout), 32'(exp));
        last_res = exp;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        last_res = '0;
        got_res  = '0;
        start    = 1'b0;
        Ain      = '0;
        shamt    = '0;
        rst_n    = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aout", 32'(Aout), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #2;

        // Idle with start low: nothing happens.
        tick();
        tick();
        check("idle_nostart_busy", 32'(busy), 32'd0);
        check("idle_nostart_aout", 32'(Aout), 32'd0);

        run_req(16'h8001, 1, 1'b0);
        run_req(16'h1234, 0, 1'b0);
        run_req(16'h1234, 16, 1'b0);
        run_req(16'h0001, 17, 1'b0);
        run_req(16'hF00F, 4, 1'b1);
        start = 1'b0;
        run_req(16'hABCD, 15, 1'b0);
        check("rotr_equiv", 32'(got_res), 32'(ref_rotr(16'hABCD, 1)));
        check("rotr_const", 32'(got_res), 32'h0000D5E6);

        // Reset mid-rotation: shamt=8, drop rst_n after E3.
        start = 1'b1;
        Ain   = 16'h5A3C;
        shamt = SHW'(8);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_aout", 32'(Aout), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rst_no_done", 32'(done), 32'd0);
        end
        rst_n    = 1'b1;
        last_res = '0;
        #2;
        run_req(16'hC0DE, 5, 1'b0);

        // Random back-to-back requests with start held high throughout.
        for (int r = 0; r < 1000; r++) begin
            run_req(WIDTH'($urandom), int'($urandom_range(0, 31)), 1'b1);
        end
        start = 1'b0;
        tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
